// File: rtl/malcolm.sv
// malcolm: nibble-to-byte packer feeding a first-word-fall-through FIFO with valid/ready output.
// Optional stored even parity is enabled by defining MALCOLM_PARITY_EN.
module malcolm #(
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         moneytalks,
    input  logic               capture,
    input  logic               flush,
    output logic [7:0]         out_data,
    output logic               out_parity,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIFO_AW:0]   level,
    output logic               overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};
`ifdef MALCOLM_PARITY_EN
    localparam int W = 9;
`else
    localparam int W = 8;
`endif

    typedef enum logic {EMPTY, HALF} state_t;

    state_t               state, state_nxt;
    logic [3:0]           lo_q;
    logic [W-1:0]         ram [DEPTH];
    logic [W-1:0]         wdata;
    logic [W-1:0]         head;
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]           byte_w;
    logic                 byte_done, push, pop, drop, full;
    logic                 primed;

    // Packer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      state <= EMPTY;
        else if (flush) state <= EMPTY;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (capture) state_nxt = (state == EMPTY) ? HALF : EMPTY;
    end

    always_comb begin
        full      = (level == FULL_LEVEL);
        byte_done = capture && (state == HALF) && !flush;
        pop       = out_valid && out_ready && !flush;
        push      = byte_done && (!full || pop);
        drop      = byte_done && full && !pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               lo_q <= 4'h0;
        else if (flush)                          lo_q <= 4'h0;
        else if (capture && (state == EMPTY))    lo_q <= moneytalks;
    end

    assign byte_w = {moneytalks, lo_q};
`ifdef MALCOLM_PARITY_EN
    assign wdata = {^byte_w, byte_w};
`else
    assign wdata = byte_w;
`endif

    // FIFO storage: no reset, contents only meaningful below level
    always_ff @(posedge clk) begin
        if (push) ram[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            primed   <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) overflow <= 1'b1;
            if (push) primed <= 1'b1;
        end
    end

    // Head is read combinationally; forced to zero until the first write after reset
    assign head      = ram[rd_ptr];
    assign out_valid = (level != '0);
    assign out_data  = primed ? head[7:0] : 8'h00;
`ifdef MALCOLM_PARITY_EN
    assign out_parity = primed ? head[8] : 1'b0;
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_malcolm.sv
// Directed bench for malcolm (FIFO_AW=2): packing, overflow, simultaneous push/pop, flush, reset, parity.
module tb_malcolm;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] moneytalks;
    logic       capture;
    logic       flush;
    logic [7:0] out_data;
    logic       out_parity;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       overflow;

    int vecs = 0;
    int errs = 0;

    malcolm #(.FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .moneytalks(moneytalks), .capture(capture),
        .flush(flush), .out_data(out_data), .out_parity(out_parity),
        .out_valid(out_valid), .out_ready(out_ready), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic par(input logic [7:0] b);
`ifdef MALCOLM_PARITY_EN
        return ^b;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [3:0] nib);
        capture = 1'b1;
        moneytalks = nib;
        tick();
        capture = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        cap(b[3:0]);
        cap(b[7:4]);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        chk(tag, {1'b0, out_data}, {1'b0, exp});
        chk({tag, "_par"}, {8'h0, out_parity}, {8'h0, par(exp)});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; moneytalks = 4'h0; capture = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_level", {6'h0, level}, 9'h0);
        chk("rst_valid", {8'h0, out_valid}, 9'h0);
        chk("rst_data", {1'b0, out_data}, 9'h0);
        chk("rst_parity", {8'h0, out_parity}, 9'h0);
        chk("rst_ovf", {8'h0, overflow}, 9'h0);
        @(negedge clk); reset = 1'b0;

        // Basic pack with one-cycle latency
        cap(4'h3);
        chk("half_valid", {8'h0, out_valid}, 9'h0);
        cap(4'hA);
        chk("pack_valid", {8'h0, out_valid}, 9'h1);
        chk("pack_level", {6'h0, level}, 9'h1);
        pop_check("pack_data", 8'hA3);
        chk("pack_empty", {8'h0, out_valid}, 9'h0);

        // Fill and overflow
        for (int i = 1; i <= 8; i++) cap(4'(i));
        chk("fill_level", {6'h0, level}, 9'h4);
        chk("fill_noovf", {8'h0, overflow}, 9'h0);
        cap(4'h9);
        cap(4'hA);
        chk("ovf_level", {6'h0, level}, 9'h4);
        chk("ovf_set", {8'h0, overflow}, 9'h1);
        pop_check("drain0", 8'h21);
        pop_check("drain1", 8'h43);
        pop_check("drain2", 8'h65);
        pop_check("drain3", 8'h87);
        chk("drain_valid", {8'h0, out_valid}, 9'h0);
        chk("drain_level", {6'h0, level}, 9'h0);

        // Parity bytes, then asynchronous reset mid-stream with FSM in HALF
        push_byte(8'h07);
        push_byte(8'hFF);
        cap(4'h6);
        chk("pre_rst_level", {6'h0, level}, 9'h2);
        chk("par07", {8'h0, out_parity}, {8'h0, par(8'h07)});
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_level", {6'h0, level}, 9'h0);
        chk("mid_rst_valid", {8'h0, out_valid}, 9'h0);
        chk("mid_rst_data", {1'b0, out_data}, 9'h0);
        chk("mid_rst_par", {8'h0, out_parity}, 9'h0);
        chk("mid_rst_ovf", {8'h0, overflow}, 9'h0);
        @(negedge clk); reset = 1'b0;
        push_byte(8'h89);
        chk("post_rst_level", {6'h0, level}, 9'h1);
        pop_check("post_rst_data", 8'h89);
        push_byte(8'hFF);
        pop_check("parFF", 8'hFF);

        // Full FIFO with simultaneous pop on the completing capture
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        cap(4'hC);
        out_ready = 1'b1;
        cap(4'h5);
        out_ready = 1'b0;
        chk("simul_level", {6'h0, level}, 9'h4);
        chk("simul_noovf", {8'h0, overflow}, 9'h0);
        pop_check("simul0", 8'h22);
        pop_check("simul1", 8'h33);
        pop_check("simul2", 8'h44);
        pop_check("simul3", 8'h5C);
        chk("simul_empty", {8'h0, out_valid}, 9'h0);

        // Flush with overflow set, level 3, FSM in HALF, capture and ready high
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        push_byte(8'h65);
        chk("flush_pre_ovf", {8'h0, overflow}, 9'h1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        cap(4'h7);
        chk("flush_pre_level", {6'h0, level}, 9'h3);
        flush = 1'b1; capture = 1'b1; moneytalks = 4'hE; out_ready = 1'b1;
        tick();
        flush = 1'b0; capture = 1'b0; out_ready = 1'b0;
        chk("flush_level", {6'h0, level}, 9'h0);
        chk("flush_valid", {8'h0, out_valid}, 9'h0);
        chk("flush_ovf", {8'h0, overflow}, 9'h1);
        push_byte(8'h32);
        chk("flush_fsm_level", {6'h0, level}, 9'h1);
        pop_check("flush_fsm_data", 8'h32);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

endmodule
